// File: rtl/multicycle_control.sv
// Multicycle RISC-V main control FSM: sequences fetch, decode, memory, ALU,
// branch and jal steps and drives the datapath strobes and mux selects.
module multicycle_control (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       PC_WRITE,
  output logic       IR_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       ADR_SRC,
  output logic [1:0] ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [1:0] RESULT_SRC,
  output logic [1:0] ALU_OP,
  output logic [3:0] STATE,
  output logic       ILLEGAL
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t state;

  // Unused codes 12-15 fall into the default arm and recover to FETCH.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    state <= MEM_READY ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (OPCODE)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEMADR:   state <= (OPCODE == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= MEM_READY ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: state <= MEM_READY ? S_FETCH : S_MEMWRITE;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PC_WRITE   = 1'b0;
    IR_WRITE   = 1'b0;
    REG_WRITE  = 1'b0;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    ADR_SRC    = 1'b0;
    ALU_SRC_A  = 2'b00;
    ALU_SRC_B  = 2'b00;
    RESULT_SRC = 2'b00;
    ALU_OP     = 2'b00;
    ILLEGAL    = 1'b0;
    case (state)
      S_FETCH: begin
        MEM_READ   = 1'b1;
        ALU_SRC_B  = 2'b10;
        ALU_OP     = 2'b10;
        RESULT_SRC = 2'b10;
        IR_WRITE   = MEM_READY;
        PC_WRITE   = MEM_READY;
      end
      S_DECODE: begin
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 2'b01;
        ALU_OP    = 2'b10;
      end
      S_MEMADR: begin
        ALU_SRC_A = 2'b10;
        ALU_SRC_B = 2'b01;
        ALU_OP    = 2'b10;
      end
      S_MEMREAD: begin
        MEM_READ = 1'b1;
        ADR_SRC  = 1'b1;
      end
      S_MEMWB: begin
        RESULT_SRC = 2'b01;
        REG_WRITE  = 1'b1;
      end
      S_MEMWRITE: begin
        MEM_WRITE = 1'b1;
        ADR_SRC   = 1'b1;
      end
      S_EXECR: begin
        ALU_SRC_A = 2'b10;
      end
      S_EXECI: begin
        ALU_SRC_A = 2'b10;
        ALU_SRC_B = 2'b01;
        ALU_OP    = 2'b11;
      end
      S_ALUWB: begin
        REG_WRITE = 1'b1;
      end
      // beq takes the branch on ZERO, bne on !ZERO; other funct3 never branch.
      S_BRANCH: begin
        ALU_SRC_A = 2'b10;
        ALU_OP    = 2'b01;
        PC_WRITE  = (FUNCT3[2:1] == 2'b00) ? (ZERO ^ FUNCT3[0]) : 1'b0;
      end
      S_JAL: begin
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 2'b10;
        ALU_OP    = 2'b10;
        PC_WRITE  = 1'b1;
      end
      S_TRAP: begin
        ILLEGAL = 1'b1;
      end
      default: begin
      end
    endcase
    // Architectural writes are suppressed while reset is held.
    if (RESET) begin
      PC_WRITE  = 1'b0;
      IR_WRITE  = 1'b0;
      REG_WRITE = 1'b0;
      MEM_WRITE = 1'b0;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes its expected
// state and outputs, and a negedge monitor pops and compares them.
module tb_multicycle_control;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic       ZERO;
  logic       MEM_READY;
  logic       PC_WRITE, IR_WRITE, REG_WRITE, MEM_READ, MEM_WRITE, ADR_SRC;
  logic [1:0] ALU_SRC_A, ALU_SRC_B, RESULT_SRC, ALU_OP;
  logic [3:0] STATE;
  logic       ILLEGAL;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [14:0] outs;
  } exp_t;

  exp_t sb[$];

  multicycle_control dut (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .FUNCT3(FUNCT3), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE),
    .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .ADR_SRC(ADR_SRC), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
    .RESULT_SRC(RESULT_SRC), .ALU_OP(ALU_OP), .STATE(STATE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Output table per state, packed as
  // {pcw, irw, rw, mr, mw, adr, srcA, srcB, resSrc, aluOp, illegal}.
  function automatic logic [14:0] expOutputs(input logic [3:0] st, input logic rst,
                                             input logic rdy, input logic z,
                                             input logic [2:0] f3);
    logic pcw, irw, rw, mr, mw, adr, ill;
    logic [1:0] a, b, rs, op;
    {pcw, irw, rw, mr, mw, adr, ill} = '0;
    {a, b, rs, op} = '0;
    case (st)
      4'd0:  begin mr = 1; b = 2'b10; op = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01; op = 2'b10; end
      4'd2:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      4'd3:  begin mr = 1; adr = 1; end
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin mw = 1; adr = 1; end
      4'd6:  begin a = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; op = 2'b11; end
      4'd8:  begin rw = 1; end
      4'd9:  begin
        a = 2'b10; op = 2'b01;
        if (f3 == 3'b000) pcw = z;
        else if (f3 == 3'b001) pcw = ~z;
      end
      4'd10: begin a = 2'b01; b = 2'b10; op = 2'b10; pcw = 1; end
      4'd11: begin ill = 1; end
      default: begin end
    endcase
    if (rst) {pcw, irw, rw, mw} = '0;
    return {pcw, irw, rw, mr, mw, adr, a, b, rs, op, ill};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and records what that cycle must show.
  task automatic applyStimulus(input string tag, input logic rst, input logic [6:0] op,
                               input logic [2:0] f3, input logic z, input logic rdy,
                               input logic [3:0] expState);
    exp_t e;
    RESET = rst; OPCODE = op; FUNCT3 = f3; ZERO = z; MEM_READY = rdy;
    e.tag = tag;
    e.st = expState;
    e.outs = expOutputs(expState, rst, rdy, z, f3);
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.tag, "_state"}, {28'd0, STATE}, {28'd0, e.st});
      checkOutput({e.tag, "_outs"},
                  {17'd0, PC_WRITE, IR_WRITE, REG_WRITE, MEM_READ, MEM_WRITE, ADR_SRC,
                   ALU_SRC_A, ALU_SRC_B, RESULT_SRC, ALU_OP, ILLEGAL},
                  {17'd0, e.outs});
    end
  end

  initial begin
    RESET = 1'b1; OPCODE = OP_LW; FUNCT3 = 3'b000; ZERO = 1'b0; MEM_READY = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    applyStimulus("reset", 1, OP_LW, 3'b000, 0, 1, 4'd0);

    // lw with fetch and memory wait states
    applyStimulus("lw", 0, OP_LW, 3'b010, 0, 0, 4'd0);
    applyStimulus("lw", 0, OP_LW, 3'b010, 0, 0, 4'd0);
    applyStimulus("lw", 0, OP_LW, 3'b010, 0, 1, 4'd0);
    applyStimulus("lw", 0, OP_LW, 3'b010, 0, 1, 4'd1);
    applyStimulus("lw", 0, OP_LW, 3'b010, 0, 1, 4'd2);
    for (int i = 0; i < 3; i++) applyStimulus("lw", 0, OP_LW, 3'b010, 0, 0, 4'd3);
    applyStimulus("lw", 0, OP_LW, 3'b010, 0, 1, 4'd3);
    applyStimulus("lw", 0, OP_LW, 3'b010, 0, 1, 4'd4);

    // sw, zero-wait
    applyStimulus("sw", 0, OP_SW, 3'b010, 0, 1, 4'd0);
    applyStimulus("sw", 0, OP_SW, 3'b010, 0, 1, 4'd1);
    applyStimulus("sw", 0, OP_SW, 3'b010, 0, 1, 4'd2);
    applyStimulus("sw", 0, OP_SW, 3'b010, 0, 1, 4'd5);

    applyStimulus("rtype", 0, OP_R, 3'b000, 1, 1, 4'd0);
    applyStimulus("rtype", 0, OP_R, 3'b000, 1, 1, 4'd1);
    applyStimulus("rtype", 0, OP_R, 3'b000, 1, 1, 4'd6);
    applyStimulus("rtype", 0, OP_R, 3'b000, 1, 1, 4'd8);
    applyStimulus("itype", 0, OP_I, 3'b000, 0, 1, 4'd0);
    applyStimulus("itype", 0, OP_I, 3'b000, 0, 1, 4'd1);
    applyStimulus("itype", 0, OP_I, 3'b000, 0, 1, 4'd7);
    applyStimulus("itype", 0, OP_I, 3'b000, 0, 1, 4'd8);

    // beq taken, bne not taken, funct3=100 never writes PC
    applyStimulus("beq", 0, OP_BR, 3'b000, 1, 1, 4'd0);
    applyStimulus("beq", 0, OP_BR, 3'b000, 1, 1, 4'd1);
    applyStimulus("beq", 0, OP_BR, 3'b000, 1, 1, 4'd9);
    applyStimulus("bne", 0, OP_BR, 3'b001, 1, 1, 4'd0);
    applyStimulus("bne", 0, OP_BR, 3'b001, 1, 1, 4'd1);
    applyStimulus("bne", 0, OP_BR, 3'b001, 1, 1, 4'd9);
    applyStimulus("blt", 0, OP_BR, 3'b100, 1, 1, 4'd0);
    applyStimulus("blt", 0, OP_BR, 3'b100, 1, 1, 4'd1);
    applyStimulus("blt", 0, OP_BR, 3'b100, 1, 1, 4'd9);
    applyStimulus("bne0", 0, OP_BR, 3'b001, 0, 1, 4'd0);
    applyStimulus("bne0", 0, OP_BR, 3'b001, 0, 1, 4'd1);
    applyStimulus("bne0", 0, OP_BR, 3'b001, 0, 1, 4'd9);

    applyStimulus("jal", 0, OP_JAL, 3'b000, 0, 1, 4'd0);
    applyStimulus("jal", 0, OP_JAL, 3'b000, 0, 1, 4'd1);
    applyStimulus("jal", 0, OP_JAL, 3'b000, 0, 1, 4'd10);
    applyStimulus("jal", 0, OP_JAL, 3'b000, 0, 1, 4'd8);

    // reset while sw waits on memory
    applyStimulus("swrst", 0, OP_SW, 3'b010, 0, 1, 4'd0);
    applyStimulus("swrst", 0, OP_SW, 3'b010, 0, 1, 4'd1);
    applyStimulus("swrst", 0, OP_SW, 3'b010, 0, 1, 4'd2);
    applyStimulus("swrst", 0, OP_SW, 3'b010, 0, 0, 4'd5);
    applyStimulus("swrst", 1, OP_SW, 3'b010, 0, 0, 4'd5);
    applyStimulus("swrst", 0, OP_SW, 3'b010, 0, 0, 4'd0);
    applyStimulus("swrst", 0, OP_SW, 3'b010, 0, 1, 4'd0);

    // illegal opcode traps until reset
    applyStimulus("trap", 0, OP_BAD, 3'b000, 1, 1, 4'd1);
    for (int i = 0; i < 10; i++) applyStimulus("trap", 0, OP_BAD, 3'b000, 1, 1, 4'd11);
    applyStimulus("trap", 1, OP_BAD, 3'b000, 1, 1, 4'd11);
    applyStimulus("trap", 0, OP_LW, 3'b000, 0, 1, 4'd0);
    applyStimulus("trap", 0, OP_LW, 3'b000, 0, 1, 4'd1);

    @(negedge CLK);
    #1;
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset, named CLK and RESET.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RESET  in  1  synchronous, active-high; sampled on CLK rising edge.
REQ-004 OPCODE  in  7  instruction register bits [6:0].
REQ-005 FUNCT3  in  3  instruction register bits [14:12].
REQ-006 ZERO  in  1  ALU zero flag from the current cycle's ALU result.
REQ-007 MEM_READY  in  1  memory handshake: access completes in the cycle it is high.
REQ-008 PC_WRITE, IR_WRITE, REG_WRITE, MEM_READ, MEM_WRITE, ADR_SRC  out  1 each  datapath strobes and selects.
REQ-009 ALU_SRC_A  out  2  00 PC, 01 oldPC, 10 rs1.
REQ-010 ALU_SRC_B  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-011 RESULT_SRC  out  2  00 ALUOut, 01 read data, 10 ALU result.
REQ-012 ALU_OP  out  2  to ALU control: 00 R-type, 01 branch, 10 add (load/store/address), 11 I-type.
REQ-013 STATE  out  4  current state code; ILLEGAL  out  1  high while in TRAP.

Function
REQ-014 States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-015 Outputs SHALL be combinational from STATE, MEM_READY, ZERO and FUNCT3 (Moore plus gated strobes); any output not listed for a state SHALL be 0.
REQ-016 FETCH: MEM_READ=1, ADR_SRC=0, A=00, B=10, ALU_OP=10, RESULT_SRC=10; IR_WRITE=PC_WRITE=MEM_READY; stay while MEM_READY=0, else go to DECODE.
REQ-017 DECODE: A=01, B=01, ALU_OP=10; next by OPCODE: 0000011 or 0100011 to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BRANCH, 1101111 to JAL, any other to TRAP.
REQ-018 MEMADR: A=10, B=01, ALU_OP=10; to MEMREAD if OPCODE=0000011, else to MEMWRITE.
REQ-019 MEMREAD: MEM_READ=1, ADR_SRC=1, RESULT_SRC=00; hold until MEM_READY=1, then go to MEMWB.
REQ-020 MEMWB: RESULT_SRC=01, REG_WRITE=1; go to FETCH.
REQ-021 MEMWRITE: MEM_WRITE=1, ADR_SRC=1, RESULT_SRC=00; hold until MEM_READY=1, then go to FETCH.
REQ-022 EXECR: A=10, B=00, ALU_OP=00. EXECI: A=10, B=01, ALU_OP=11. Both go to ALUWB.
REQ-023 ALUWB: RESULT_SRC=00, REG_WRITE=1; go to FETCH.
REQ-024 BRANCH: A=10, B=00, ALU_OP=01, RESULT_SRC=00; PC_WRITE=(ZERO XOR FUNCT3[0]) when FUNCT3 is 000 or 001, else 0; go to FETCH.
REQ-025 JAL: A=01, B=10, ALU_OP=10, RESULT_SRC=00, PC_WRITE=1; go to ALUWB so that rd receives oldPC+4.
REQ-026 TRAP: all strobes 0, ILLEGAL=1; hold until RESET.
REQ-027 Latency with MEM_READY=1 throughout SHALL be: lw 5 cycles, sw 4, R/I 4, branch 3, jal 4, counted from FETCH entry to the next FETCH entry.
REQ-028 MEM_WRITE, REG_WRITE, PC_WRITE and IR_WRITE SHALL be 0 in every cycle where RESET=1.

Reset
REQ-029 RESET=1 SHALL force STATE to FETCH (0) at the next edge from any state, including mid-wait in MEMREAD/MEMWRITE and from TRAP.
REQ-030 After RESET, the first cycle SHALL present FETCH outputs with ILLEGAL=0.

Verification
REQ-031 Stimulus: lw opcode, MEM_READY low for 2 cycles in FETCH and 3 cycles in MEMREAD. Required: STATE 0,0,0,1,2,3,3,3,3,4,0; REG_WRITE=1 only in state 4.
REQ-032 Stimulus: R-type 0110011 then I-type 0010011, MEM_READY=1. Required: STATE 0,1,6,8 with ALU_OP=00 in state 6, then 0,1,7,8 with ALU_OP=11 in state 7.
REQ-033 Stimulus: BEQ (FUNCT3=000) with ZERO=1, then BNE (FUNCT3=001) with ZERO=1, then FUNCT3=100. Required: PC_WRITE=1, then 0, then 0 in the BRANCH cycle.
REQ-034 Stimulus: jal 1101111. Required: STATE 0,1,10,8,0; PC_WRITE=1 in state 10; REG_WRITE=1 in state 8.
REQ-035 Stimulus: opcode 1111111. Required: STATE 11 with ILLEGAL=1 and no strobes for 10 cycles; RESET pulse returns STATE to 0.
REQ-036 Stimulus: RESET asserted during MEMWRITE wait. Required: MEM_WRITE=0 in the reset cycle; STATE=0 on the next cycle.
